// File: rtl/pc_fetch_ctrl.sv
// Program-counter owner and instruction-fetch sequencer for the RV32I core.
// One req/gnt/rvalid fetch per instruction, then waits for execute completion.
package singlecycle_pkg;
    typedef enum logic {
        PC_4   = 1'b0,
        PC_ALU = 1'b1
    } PCSel_e;
endpackage

module pc_fetch_ctrl
    import singlecycle_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned MAX_WAIT     = 15
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_imem_err,
    output logic [31:0] o_pc,
    output logic [31:0] o_instr,
    output logic        o_instr_valid,
    input  logic        i_exec_done,
    input  logic        i_stall,
    input  PCSel_e      i_pc_sel,
    input  logic [31:0] i_alu_res,
    output logic        o_pc_en,
    output PCSel_e      o_pc_sel,
    output logic        o_trap,
    output logic [1:0]  o_trap_cause,
    output logic [31:0] o_instret
);

    localparam logic [2:0] S_BOOT = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_EXEC = 3'd3;
    localparam logic [2:0] S_HALT = 3'd4;

    localparam logic [1:0] CAUSE_NONE      = 2'd0;
    localparam logic [1:0] CAUSE_FETCH_ERR = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT   = 2'd2;
    localparam logic [1:0] CAUSE_MISALIGN  = 2'd3;

    // Counter value seen in the final permitted S_WAIT cycle (counter starts at 0).
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    logic [2:0]  state_reg,   state_next;
    logic [31:0] pc_reg,      pc_next;
    logic [31:0] instr_reg,   instr_next;
    logic [31:0] instret_reg, instret_next;
    logic [7:0]  wait_cnt_reg, wait_cnt_next;
    logic        trap_reg,    trap_next;
    logic [1:0]  cause_reg,   cause_next;

    logic [31:0] target;
    logic        exec_fire;
    logic        target_aligned;

    always_comb begin
        target         = (i_pc_sel == PC_ALU) ? i_alu_res : pc_reg + 32'd4;
        target_aligned = (target[1:0] == 2'b00);
        exec_fire      = (state_reg == S_EXEC) && i_exec_done && !i_stall;
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        instr_next    = instr_reg;
        instret_next  = instret_reg;
        wait_cnt_next = wait_cnt_reg;
        trap_next     = trap_reg;
        cause_next    = cause_reg;

        case (state_reg)
            S_BOOT: begin
                state_next = S_REQ;
            end
            S_REQ: begin
                if (i_imem_gnt) begin
                    state_next    = S_WAIT;
                    wait_cnt_next = 8'd0;
                end
            end
            S_WAIT: begin
                wait_cnt_next = wait_cnt_reg + 8'd1;
                // A response in the last permitted cycle still beats the timeout.
                if (i_imem_rvalid) begin
                    if (i_imem_err) begin
                        state_next = S_HALT;
                        trap_next  = 1'b1;
                        cause_next = CAUSE_FETCH_ERR;
                    end else begin
                        instr_next = i_imem_rdata;
                        state_next = S_EXEC;
                    end
                end else if (wait_cnt_reg == WAIT_LAST) begin
                    state_next = S_HALT;
                    trap_next  = 1'b1;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            S_EXEC: begin
                if (exec_fire) begin
                    if (target_aligned) begin
                        pc_next      = target;
                        instret_next = instret_reg + 32'd1;
                        state_next   = S_REQ;
                    end else begin
                        // PC keeps the address of the instruction that produced the bad target.
                        state_next = S_HALT;
                        trap_next  = 1'b1;
                        cause_next = CAUSE_MISALIGN;
                    end
                end
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg    <= S_BOOT;
            pc_reg       <= RESET_VECTOR;
            instr_reg    <= 32'd0;
            instret_reg  <= 32'd0;
            wait_cnt_reg <= 8'd0;
            trap_reg     <= 1'b0;
            cause_reg    <= CAUSE_NONE;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            instr_reg    <= instr_next;
            instret_reg  <= instret_next;
            wait_cnt_reg <= wait_cnt_next;
            trap_reg     <= trap_next;
            cause_reg    <= cause_next;
        end
    end

    assign o_imem_req    = (state_reg == S_REQ);
    assign o_imem_addr   = pc_reg;
    assign o_pc          = pc_reg;
    assign o_instr       = instr_reg;
    assign o_instr_valid = (state_reg == S_EXEC);
    assign o_pc_en       = exec_fire && target_aligned;
    assign o_pc_sel      = i_pc_sel;
    assign o_trap        = trap_reg;
    assign o_trap_cause  = cause_reg;
    assign o_instret     = instret_reg;

endmodule
